// File: rtl/alu_result_register_pkg.sv
// Shared definitions for the ALU result register: data/op widths and the
// load hold-off FSM state encoding.
package alu_result_register_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Hold-off counter width; a single-cycle hold-off still needs one bit.
    function automatic int unsigned holdoff_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage : alu_result_register_pkg

// File: rtl/alu_result_register_load_edge_holdoff.sv
// Load button edge detector with hold-off/release FSM. Emits a one-cycle
// capture enable on an accepted rising edge of load and reports readiness.
module load_edge_holdoff
    import alu_result_register_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic ready,
    output logic cap_en
);

    localparam int unsigned HW = holdoff_cnt_w(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES - 1);

    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be at least 1");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_load_q;
    logic [HW-1:0]   r_hold_cnt;
    logic            w_rise;
    logic            w_ready;
    logic            w_cap_en;

    assign w_rise = load & ~r_load_q;

    // load_q resets high so a button held through reset is not seen as a rise.
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_load_q <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_load_q <= load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (w_cap_en) begin
            r_hold_cnt <= HOLD_INIT;
        end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_cap_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_rise) begin
                    w_cap_en    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!load) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready  = w_ready;
    assign cap_en = w_cap_en;

endmodule : load_edge_holdoff

// File: rtl/alu_result_register.sv
// Accumulator stage behind the switch-driven ALU: captures result/op on a
// debounced load edge, counts captures, feeds acc[3:0] back as operand B.
// Optional macro ALU_RESULT_HISTORY_EN adds prev_out and delta_out.
module alu_result_register
    import alu_result_register_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [OP_W-1:0]   op_in,
    input  logic              load,
    input  logic              clear,
    output logic [DATA_W-1:0] acc_out,
    output logic [OP_W-1:0]   op_out,
    output logic [3:0]        b_feedback,
    output logic              ready,
    output logic              captured,
    output logic [CNT_W-1:0]  cap_count
`ifdef ALU_RESULT_HISTORY_EN
    ,
    output logic [DATA_W-1:0] prev_out,
    output logic [DATA_W:0]   delta_out
`endif
);

    logic              w_cap_en;
    logic              w_ready;
    logic [DATA_W-1:0] r_acc;
    logic [OP_W-1:0]   r_op;
    logic [CNT_W-1:0]  r_cap_count;
    logic              r_captured;

    load_edge_holdoff #(
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_load_edge_holdoff (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .ready  (w_ready),
        .cap_en (w_cap_en)
    );

    // clear takes priority over capture data but not over the capture itself:
    // a simultaneous capture still counts and pulses captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_op  <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_op  <= '0;
        end else if (w_cap_en) begin
            r_acc <= alu_in;
            r_op  <= op_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_count <= '0;
            r_captured  <= 1'b0;
        end else begin
            r_captured <= w_cap_en;
            if (w_cap_en) begin
                r_cap_count <= r_cap_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_RESULT_HISTORY_EN
    logic [DATA_W-1:0] r_prev;

    // A capture records the old accumulator even when clear hits the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
        end else if (w_cap_en) begin
            r_prev <= r_acc;
        end else if (clear) begin
            r_prev <= '0;
        end
    end

    assign prev_out  = r_prev;
    assign delta_out = {1'b0, r_acc} - {1'b0, r_prev};
`endif

    assign acc_out    = r_acc;
    assign op_out     = r_op;
    assign b_feedback = r_acc[3:0];
    assign ready      = w_ready;
    assign captured   = r_captured;
    assign cap_count  = r_cap_count;

endmodule : alu_result_register
